// File: rtl/alsu_gen_pkg.sv
// -----------------------------------------------------------------------------
// alsu_gen_pkg
// Shared definitions for the parametrised ALSU: the opcode map, the LED blink
// start pattern, and the error-counter width.
// Optional feature macro used by the top level: ALSU_GEN_ERRCNT_EN.
// -----------------------------------------------------------------------------
package alsu_gen_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_XOR   = 3'd1,
        OP_ADD   = 3'd2,
        OP_MUL   = 3'd3,
        OP_SHIFT = 3'd4,
        OP_ROT   = 3'd5,
        OP_INV6  = 3'd6,
        OP_INV7  = 3'd7
    } opcode_e;

    localparam logic [15:0] LED_BLINK_INIT = 16'hFFFF;
    localparam int          ERRCNT_W       = 8;

    // Opcodes 6 and 7 have no defined operation.
    function automatic logic op_is_invalid(input opcode_e op);
        return (op == OP_INV6) || (op == OP_INV7);
    endfunction

    // Reductions are only meaningful for the two bitwise opcodes.
    function automatic logic op_allows_reduction(input opcode_e op);
        return (op == OP_AND) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/alsu_gen_shreg.sv
// -----------------------------------------------------------------------------
// alsu_gen_shreg
// Next-value logic for the 2*WIDTH result/shift register. Shifts one position
// per operation; the fill bit is serial_in for a shift, or the bit leaving the
// opposite end for a rotate.
// Ports:
//   cur        - current register contents
//   serial_in  - fill bit for plain shifts
//   direction  - 1 = left, 0 = right
//   rotate     - 1 = rotate, 0 = shift
//   nxt        - shifted/rotated value
// -----------------------------------------------------------------------------
module alsu_gen_shreg #(
    parameter int W = 8
) (
    input  logic [W-1:0] cur,
    input  logic         serial_in,
    input  logic         direction,
    input  logic         rotate,
    output logic [W-1:0] nxt
);

    logic fill_s;

    // Select fill bit and form the shifted word.
    always_comb begin
        fill_s = 1'b0;
        nxt    = cur;
        if (direction) begin
            fill_s = rotate ? cur[W-1] : serial_in;
            nxt    = {cur[W-2:0], fill_s};
        end else begin
            fill_s = rotate ? cur[0] : serial_in;
            nxt    = {fill_s, cur[W-1:1]};
        end
    end

endmodule

// File: rtl/alsu_gen.sv
// -----------------------------------------------------------------------------
// alsu_gen
// WIDTH-bit arithmetic/logic/shift unit, two-stage valid-qualified pipeline.
// Stage 1 registers operands and controls; stage 2 evaluates and updates the
// 2*WIDTH result/shift register, the LED error blinker and the error counter.
// Optional feature: define ALSU_GEN_ERRCNT_EN to build the saturating
// invalid-operation counter; otherwise err_cnt is constant zero.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   in_valid           - qualifies all operand/control inputs
//   A, B               - operands
//   opcode             - 0 AND,1 XOR,2 ADD,3 MUL,4 SHIFT,5 ROTATE,6/7 invalid
//   cin                - carry in for ADD (when FULL_ADDER == "ON")
//   serial_in          - shift fill bit
//   direction          - 1 = left, 0 = right
//   red_op_A/B         - reduction selects
//   bypass_A/B         - bypass selects
//   out, out_valid     - result register and its update strobe
//   leds               - error blinker
//   err_cnt            - saturating invalid-operation count
// -----------------------------------------------------------------------------
module alsu_gen
    import alsu_gen_pkg::*;
#(
    parameter int    WIDTH          = 4,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [2:0]            opcode,
    input  logic                  cin,
    input  logic                  serial_in,
    input  logic                  direction,
    input  logic                  red_op_A,
    input  logic                  red_op_B,
    input  logic                  bypass_A,
    input  logic                  bypass_B,
    output logic [2*WIDTH-1:0]    out,
    output logic                  out_valid,
    output logic [15:0]           leds,
    output logic [ERRCNT_W-1:0]   err_cnt
);

    localparam int OW       = 2 * WIDTH;
    localparam bit PRIO_B   = (INPUT_PRIORITY == "B");
    localparam bit USE_CIN  = (FULL_ADDER == "ON");

    // Stage-1 registers
    logic [WIDTH-1:0] a_r, b_r;
    opcode_e          opcode_r;
    logic             cin_r, serial_in_r, direction_r;
    logic             red_a_r, red_b_r, byp_a_r, byp_b_r;
    logic             s1_valid_r;

    // Stage-2 registers
    logic [OW-1:0]    out_r;
    logic             out_valid_r;
    logic             err_r;
    logic [15:0]      leds_r;

    // Stage-2 combinational terms
    logic             byp_s, byp_use_b_s;
    logic             red_any_s, red_use_b_s;
    logic [WIDTH-1:0] byp_val_s, red_x_s;
    logic             inv_s;
    logic             cin_eff_s;
    logic [WIDTH:0]   sum_s;
    logic [OW-1:0]    prod_s;
    logic [OW-1:0]    shift_nxt_s;
    logic [OW-1:0]    result_s;

    // Stage 1: capture operands/controls on valid, track valid every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            opcode_r    <= OP_AND;
            cin_r       <= 1'b0;
            serial_in_r <= 1'b0;
            direction_r <= 1'b0;
            red_a_r     <= 1'b0;
            red_b_r     <= 1'b0;
            byp_a_r     <= 1'b0;
            byp_b_r     <= 1'b0;
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                a_r         <= A;
                b_r         <= B;
                opcode_r    <= opcode_e'(opcode);
                cin_r       <= cin;
                serial_in_r <= serial_in;
                direction_r <= direction;
                red_a_r     <= red_op_A;
                red_b_r     <= red_op_B;
                byp_a_r     <= bypass_A;
                byp_b_r     <= bypass_B;
            end
        end
    end

    // Shift/rotate operate on the live result register so shifts chain.
    alsu_gen_shreg #(
        .W (OW)
    ) u_shreg (
        .cur       (out_r),
        .serial_in (serial_in_r),
        .direction (direction_r),
        .rotate    (opcode_r == OP_ROT),
        .nxt       (shift_nxt_s)
    );

    // Stage 2: operand selection, arithmetic and priority-ordered result.
    always_comb begin
        byp_s       = byp_a_r | byp_b_r;
        // When both selects are set the configured input wins.
        byp_use_b_s = (byp_a_r & byp_b_r) ? PRIO_B : byp_b_r;
        byp_val_s   = byp_use_b_s ? b_r : a_r;

        red_any_s   = red_a_r | red_b_r;
        red_use_b_s = (red_a_r & red_b_r) ? PRIO_B : red_b_r;
        red_x_s     = red_use_b_s ? b_r : a_r;

        // Bypass outranks every invalid condition.
        inv_s = ~byp_s & (op_is_invalid(opcode_r) |
                          (red_any_s & ~op_allows_reduction(opcode_r)));

        cin_eff_s = USE_CIN ? cin_r : 1'b0;
        sum_s     = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_eff_s};
        prod_s    = OW'(a_r) * OW'(b_r);

        result_s = '0;
        case (opcode_r)
            OP_AND: begin
                if (red_any_s) begin
                    result_s = {{(OW-1){1'b0}}, &red_x_s};
                end else begin
                    result_s = {{WIDTH{1'b0}}, a_r & b_r};
                end
            end
            OP_XOR: begin
                if (red_any_s) begin
                    result_s = {{(OW-1){1'b0}}, ^red_x_s};
                end else begin
                    result_s = {{WIDTH{1'b0}}, a_r ^ b_r};
                end
            end
            OP_ADD:   result_s = {{(WIDTH-1){1'b0}}, sum_s};
            OP_MUL:   result_s = prod_s;
            OP_SHIFT: result_s = shift_nxt_s;
            OP_ROT:   result_s = shift_nxt_s;
            default:  result_s = '0;
        endcase

        if (byp_s) begin
            result_s = {{WIDTH{1'b0}}, byp_val_s};
        end else if (inv_s) begin
            result_s = '0;
        end else begin
            result_s = result_s;
        end
    end

    // Stage 2: result register, valid strobe and LED error blinker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            leds_r      <= 16'h0000;
        end else begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_r <= result_s;
            end
            if (s1_valid_r && inv_s) begin
                err_r  <= 1'b1;
                // A fresh error starts all-on; a repeat keeps the blink going.
                leds_r <= err_r ? ~leds_r : LED_BLINK_INIT;
            end else if (s1_valid_r) begin
                err_r  <= 1'b0;
                leds_r <= 16'h0000;
            end else if (err_r) begin
                leds_r <= ~leds_r;
            end else begin
                leds_r <= 16'h0000;
            end
        end
    end

`ifdef ALSU_GEN_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_r;

    // Saturating count of invalid operations reaching stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else if (s1_valid_r && inv_s && (err_cnt_r != {ERRCNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERRCNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = '0;
`endif

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign leds      = leds_r;

endmodule

// File: tb/tb_alsu_gen.sv
// -----------------------------------------------------------------------------
// tb_alsu_gen
// Directed vectors for alsu_gen (WIDTH=4). Two instances share the stimulus:
// one with INPUT_PRIORITY "A", one with "B". Expected results are queued when
// an operation is issued and popped by a monitor whenever out_valid rises.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alsu_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A, B;
    logic [2:0] opcode;
    logic       cin, serial_in, direction;
    logic       red_op_A, red_op_B, bypass_A, bypass_B;

    logic [7:0]  out_a, out_b;
    logic        ov_a, ov_b;
    logic [15:0] leds_a, leds_b;
    logic [7:0]  cnt_a, cnt_b;

`ifdef ALSU_GEN_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [7:0]  oa;
        logic [7:0]  ob;
        logic [15:0] leds;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alsu_gen #(.WIDTH(4), .INPUT_PRIORITY("A"), .FULL_ADDER("ON")) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .out(out_a), .out_valid(ov_a), .leds(leds_a), .err_cnt(cnt_a)
    );

    alsu_gen #(.WIDTH(4), .INPUT_PRIORITY("B"), .FULL_ADDER("ON")) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .out(out_b), .out_valid(ov_b), .leds(leds_b), .err_cnt(cnt_b)
    );

    function automatic logic [7:0] ec(input int v);
        return CNT_EN ? 8'(v) : 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ctl = {red_op_A, red_op_B, bypass_A, bypass_B}; bits = {cin, serial_in, direction}
    task automatic issue(input string nm, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] ctl, input logic [2:0] bits,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic [15:0] el, input logic [7:0] ecnt);
        exp_t e;
        in_valid  = 1'b1;
        opcode    = op;
        A         = a;
        B         = b;
        {red_op_A, red_op_B, bypass_A, bypass_B} = ctl;
        {cin, serial_in, direction} = bits;
        e.name = nm; e.oa = ea; e.ob = eb; e.leds = el; e.cnt = ecnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && (ov_a || ov_b)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", {30'd0, ov_a, ov_b}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_valid_a"}, {31'd0, ov_a}, 32'd1);
                chk({mon_e.name, "_valid_b"}, {31'd0, ov_b}, 32'd1);
                chk({mon_e.name, "_out_a"}, {24'd0, out_a}, {24'd0, mon_e.oa});
                chk({mon_e.name, "_out_b"}, {24'd0, out_b}, {24'd0, mon_e.ob});
                chk({mon_e.name, "_leds"}, {16'd0, leds_a}, {16'd0, mon_e.leds});
                chk({mon_e.name, "_errcnt"}, {24'd0, cnt_a}, {24'd0, mon_e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; opcode = 3'd3; A = 4'hF; B = 4'hF;
        cin = 1'b0; serial_in = 1'b0; direction = 1'b0;
        red_op_A = 1'b0; red_op_B = 1'b0; bypass_A = 1'b0; bypass_B = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {24'd0, out_a}, 32'd0);
        chk("rst_valid", {31'd0, ov_a}, 32'd0);
        chk("rst_leds", {16'd0, leds_a}, 32'd0);
        chk("rst_errcnt", {24'd0, cnt_a}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        repeat (3) idle();
        chk("rst_hold_out", {24'd0, out_a}, 32'd0);
        chk("rst_hold_valid", {31'd0, ov_a}, 32'd0);
        chk("rst_hold_leds", {16'd0, leds_a}, 32'd0);

        //     name        op    A     B     ctl      bits     exp_a  exp_b  leds        cnt
        issue("byp_tie",   3'd7, 4'h9, 4'h6, 4'b0011, 3'b000, 8'h09, 8'h06, 16'h0000, ec(0));
        issue("add_cin",   3'd2, 4'hF, 4'hF, 4'b0000, 3'b100, 8'h1F, 8'h1F, 16'h0000, ec(0));
        issue("mul",       3'd3, 4'hF, 4'hF, 4'b0000, 3'b000, 8'hE1, 8'hE1, 16'h0000, ec(0));
        issue("and",       3'd0, 4'hC, 4'hA, 4'b0000, 3'b000, 8'h08, 8'h08, 16'h0000, ec(0));
        issue("add_nocin", 3'd2, 4'h7, 4'h8, 4'b0000, 3'b000, 8'h0F, 8'h0F, 16'h0000, ec(0));
        issue("red_and",   3'd0, 4'hF, 4'h0, 4'b1100, 3'b000, 8'h01, 8'h00, 16'h0000, ec(0));
        issue("red_xor_b", 3'd1, 4'h0, 4'h7, 4'b0100, 3'b000, 8'h01, 8'h01, 16'h0000, ec(0));
        issue("inv6_1",    3'd6, 4'h1, 4'h1, 4'b0000, 3'b000, 8'h00, 8'h00, 16'hFFFF, ec(1));
        issue("inv6_2",    3'd6, 4'h1, 4'h1, 4'b0000, 3'b000, 8'h00, 8'h00, 16'h0000, ec(2));
        issue("inv6_3",    3'd6, 4'h1, 4'h1, 4'b0000, 3'b000, 8'h00, 8'h00, 16'hFFFF, ec(3));
        issue("xor_clr",   3'd1, 4'h3, 4'h5, 4'b0000, 3'b000, 8'h06, 8'h06, 16'h0000, ec(3));
        issue("red_inv",   3'd2, 4'h5, 4'h3, 4'b1000, 3'b000, 8'h00, 8'h00, 16'hFFFF, ec(4));
        idle();
        idle();
        chk("blink_off", {16'd0, leds_a}, 32'h0000);
        chk("blink_out_hold", {24'd0, out_a}, 32'd0);
        idle();
        chk("blink_on", {16'd0, leds_a}, 32'hFFFF);

        issue("byp_a3",    3'd0, 4'h3, 4'h9, 4'b0010, 3'b000, 8'h03, 8'h03, 16'h0000, ec(4));
        issue("ror",       3'd5, 4'h0, 4'h0, 4'b0000, 3'b000, 8'h81, 8'h81, 16'h0000, ec(4));
        issue("rol",       3'd5, 4'h0, 4'h0, 4'b0000, 3'b001, 8'h03, 8'h03, 16'h0000, ec(4));
        issue("shr_s1",    3'd4, 4'hF, 4'hF, 4'b0000, 3'b010, 8'h81, 8'h81, 16'h0000, ec(4));
        issue("shl_s0",    3'd4, 4'h0, 4'h0, 4'b0000, 3'b001, 8'h02, 8'h02, 16'h0000, ec(4));

        for (int i = 0; i < 20 && sbq.size() != 0; i++) idle();
        chk("drain", sbq.size(), 32'd0);
        chk("pre_rst_out", {24'd0, out_a}, 32'h02);

        // Reset while an operation sits in stage 1: it must never appear.
        in_valid = 1'b1; opcode = 3'd1; A = 4'hF; B = 4'h0;
        {red_op_A, red_op_B, bypass_A, bypass_B} = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out", {24'd0, out_a}, 32'd0);
        chk("midrst_errcnt", {24'd0, cnt_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("midrst_no_valid", {30'd0, ov_a, ov_b}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
